avaliacao_escalonador: RTL and testbench
========================================

// Module: avaliacao_escalonador
// PURPOSE
//   Round-robin scheduler sharing one combinational `principal` evaluator (e[1:0], p[3:0] -> y[1:0], seg[6:0])
//   between N_REQ requesters. Grants one requester, drives its e/p onto the shared datapath and waits for settle.
//   Then captures y/seg into registers and holds the result on the display for a fixed time.
//   Sits between the requester ports and the single `principal` instance at top level.
// PARAMETERS
//   N_REQ          4   number of requesters (>=2); ID width IW = $clog2(N_REQ)
//   SETTLE_CYCLES  1   cycles e_sel/p_sel are held stable before capture (>=1)
//   HOLD_CYCLES    4   cycles captured result is held before next arbitration (>=1)
// PORTS
//   clk      in   1          rising-edge clock
//   rst      in   1          asynchronous reset, active-high
//   req      in   N_REQ      request vector, one bit per requester
//   e_bus    in   2*N_REQ    e code of requester i at [2i+1:2i]
//   p_bus    in   4*N_REQ    p word of requester i at [4i+3:4i]
//   gnt      out  N_REQ      one-hot grant, high during SETTLE
//   done     out  N_REQ      one-hot 1-cycle pulse: result for requester i captured
//   e_sel    out  2          e driven to principal
//   p_sel    out  4          p driven to principal
//   y_in     in   2          principal y1,y0
//   seg_in   in   7          principal seg_a..seg_g
//   y_out    out  2          captured y
//   seg_out  out  7          captured segments (active-high, seg_a = bit 0)
//   res_id   out  IW         index of requester owning y_out/seg_out
//   busy     out  1          high from grant edge until HOLD ends
// BEHAVIOUR
//   - Reset (async, immediate): all outputs 0; state=IDLE; rr pointer=N_REQ-1 (req[0] highest priority first).
//   - States: IDLE -> SETTLE -> CAPTURE -> HOLD -> IDLE; all outputs registered.
//   - IDLE: on edge with req!=0, pick first set bit scanning ptr+1, ptr+2, ... (mod N_REQ); register gnt,
//     e_sel/p_sel from that slice, ptr<=winner, busy<=1, -> SETTLE. req==0: stay, busy=0.
//   - SETTLE: count SETTLE_CYCLES cycles; e_sel/p_sel/gnt frozen (e_bus/p_bus changes ignored) -> CAPTURE.
//   - CAPTURE (1 cycle): y_out<=y_in, seg_out<=seg_in, res_id<=winner; done[winner] pulses the following cycle;
//     gnt<=0 -> HOLD.
//   - HOLD: count HOLD_CYCLES; y_out/seg_out/res_id stable; e_sel/p_sel keep last values -> IDLE, busy<=0.
//   - Latency: req seen at edge k -> gnt at k; capture edge k+SETTLE_CYCLES+1; done high in the cycle after it.
//     Back-to-back service period = SETTLE_CYCLES+HOLD_CYCLES+2 cycles.
//   - req dropped after grant: service still completes, done still pulses (no abort).
//   - Simultaneous requests: strict rotation; a requester holding req waits at most N_REQ-1 services.
//   - Winner == last winner allowed only if it is the sole requester.
//   - Counters sized for max(SETTLE_CYCLES,HOLD_CYCLES); no wrap during a phase.
//   - rst mid-service: aborts immediately, no done, outputs to reset values.
// CONFIGURATION
//   AVAL_BLANK_EN defined: on HOLD->IDLE, seg_out<=7'b0 and y_out<=2'b0 (display blank when idle);
//     res_id kept.
//   Not defined: y_out/seg_out retain last captured value until next capture.
// TESTING
//   Reference model: a `principal` instance fed e_sel/p_sel; expected y/seg computed from it. N_REQ=4, SETTLE=1, HOLD=4.
//   1 Reset: rst=1 mid-SETTLE -> gnt=0, done=0, busy=0, seg_out=0, y_out=0 at once; no done after release.
//   2 Single: req=4'b0100, e=2'b10, p=4'hA -> gnt=4'b0100 1 cycle; done=4'b0100 1 cycle;
//     y_out/seg_out = principal(2'b10,4'hA); res_id=2.
//   3 Rotation: req=4'b1111 held -> grant order 0,1,2,3,0; done pulses spaced 7 cycles.
//   4 Frozen inputs: change p_bus slice during SETTLE -> captured result uses p value at grant.
//   5 Sweep: requester 0 cycles all 64 {e,p} combos -> y_out/seg_out match model for each.
//   6 Macro: AVAL_BLANK_EN -> seg_out=0 from first IDLE cycle after HOLD;
//     without it -> seg_out keeps last value through 20 idle cycles.

Source files
------------

// File: rtl/avaliacao_escalonador_if.sv
// avaliacao_escalonador_if: requester, shared-evaluator and display signals of the round-robin scheduler
interface avaliacao_escalonador_if #(parameter int N_REQ = 4) ();
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] e_bus;
  logic [4*N_REQ-1:0] p_bus;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [1:0]         e_sel;
  logic [3:0]         p_sel;
  logic [1:0]         y_in;
  logic [6:0]         seg_in;
  logic [1:0]         y_out;
  logic [6:0]         seg_out;
  logic [IW-1:0]      res_id;
  logic               busy;
  modport master (
    output req, e_bus, p_bus, y_in, seg_in,
    input  gnt, done, e_sel, p_sel, y_out, seg_out, res_id, busy
  );
  modport slave (
    input  req, e_bus, p_bus, y_in, seg_in,
    output gnt, done, e_sel, p_sel, y_out, seg_out, res_id, busy
  );
endinterface

// File: rtl/avaliacao_escalonador.sv
// avaliacao_escalonador: round-robin scheduler sharing one evaluator; define AVAL_BLANK_EN to blank y_out/seg_out when idle
module avaliacao_escalonador #(
  parameter int N_REQ         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int HOLD_CYCLES   = 4
) (
  input logic clk,
  input logic rst,
  avaliacao_escalonador_if.slave bus
);
  localparam int IW   = $clog2(N_REQ);
  localparam int MAXC = SETTLE_CYCLES > HOLD_CYCLES ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, win, cand;
  logic          found;
  // rotating-priority search starting just after the last winner; the last winner itself is tried last
  always_comb begin
    win = ptr;
    cand = ptr;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (!found && bus.req[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
  end
  // phase sequencing: each phase ends when its cycle count is used up
  always_comb begin
    state_n = state == IDLE    ? (found ? SETTLE : IDLE)
            : state == SETTLE  ? (cnt == CW'(SETTLE_CYCLES - 1) ? CAPTURE : SETTLE)
            : state == CAPTURE ? HOLD
            : (cnt == CW'(HOLD_CYCLES - 1) ? IDLE : HOLD);
  end
  // state, per-phase counter (restarts on every phase change) and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= IW'(N_REQ - 1);
    end else begin
      state <= state_n;
      cnt   <= state_n != state ? '0 : cnt + 1'b1;
      if (state == IDLE && found) ptr <= win;
    end
  end
  // registered outputs: latch the winner's operands at grant so later bus changes cannot disturb the evaluator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.gnt     <= '0;
      bus.done    <= '0;
      bus.e_sel   <= '0;
      bus.p_sel   <= '0;
      bus.y_out   <= '0;
      bus.seg_out <= '0;
      bus.res_id  <= '0;
      bus.busy    <= 1'b0;
    end else begin
      bus.done <= '0;
      if (state == IDLE && found) begin
        bus.gnt   <= N_REQ'(1) << win;
        bus.e_sel <= bus.e_bus[2*win +: 2];
        bus.p_sel <= bus.p_bus[4*win +: 4];
        bus.busy  <= 1'b1;
      end
      if (state == SETTLE && state_n == CAPTURE) bus.gnt <= '0;
      if (state == CAPTURE) begin
        bus.y_out   <= bus.y_in;
        bus.seg_out <= bus.seg_in;
        bus.res_id  <= ptr;
        bus.done    <= N_REQ'(1) << ptr;
      end
      if (state == HOLD && state_n == IDLE) begin
        bus.busy <= 1'b0;
`ifdef AVAL_BLANK_EN
        bus.y_out   <= '0;
        bus.seg_out <= '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_avaliacao_escalonador.sv
// tb_avaliacao_escalonador: scoreboard bench for the round-robin evaluator scheduler
module tb_avaliacao_escalonador;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  avaliacao_escalonador_if #(.N_REQ(4)) bus ();
  avaliacao_escalonador #(.N_REQ(4), .SETTLE_CYCLES(1), .HOLD_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [3:0] done;
    logic [1:0] id;
    logic [1:0] y;
    logic [6:0] seg;
  } exp_t;
  exp_t sb[$];
  exp_t mx;
  int   done_t[$];
  int   errs = 0, checks = 0, ndone = 0, cyc = 0, base = 0;
  logic [6:0] last_seg;
  logic [1:0] last_y;
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction
  function automatic logic [8:0] princ(input logic [1:0] e, input logic [3:0] p);
    return {e ^ p[3:2], hex7(p ^ {e, e})};
  endfunction
  assign {bus.y_in, bus.seg_in} = princ(bus.e_sel, bus.p_sel);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input int id, input logic [1:0] e, input logic [3:0] p);
    bus.e_bus[2*id +: 2] = e;
    bus.p_bus[4*id +: 4] = p;
  endtask
  task automatic push(input int id, input logic [1:0] e, input logic [3:0] p);
    exp_t x;
    x.done = 4'b1 << id;
    x.id = 2'(id);
    {x.y, x.seg} = princ(e, p);
    sb.push_back(x);
  endtask
  task automatic serve(input int id, input logic [1:0] e, input logic [3:0] p);
    drive(id, e, p);
    push(id, e, p);
    @(posedge clk);
    #1 bus.req = 4'b1 << id;
    @(posedge clk);
    #1 bus.req = '0;
    @(negedge clk);
    check("gnt", bus.gnt, 4'b1 << id);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
    for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst && bus.done != '0) begin
      ndone++;
      done_t.push_back(cyc);
      if (sb.size() == 0) check("unexpected_done", bus.done, 0);
      else begin
        mx = sb.pop_front();
        check("done", bus.done, mx.done);
        check("res_id", bus.res_id, mx.id);
        check("y_out", bus.y_out, mx.y);
        check("seg_out", bus.seg_out, mx.seg);
      end
    end
  end
  initial begin
    bus.req = '0;
    bus.e_bus = 8'b01_11_00_10;
    bus.p_bus = 16'h7E51;
    repeat (2) @(negedge clk);
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_y", bus.y_out, 0);
    check("rst_seg", bus.seg_out, 0);
    check("rst_id", bus.res_id, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    serve(2, 2'b10, 4'hA);
    check("single_busy", bus.busy, 1);
    @(negedge clk);
    check("gnt_one_cycle", bus.gnt, 0);
    @(negedge clk);
    check("done_latency", bus.done, 4'b0100);
    wait_done();
    check("done_one_cycle", bus.done, 0);
    check("single_id_held", bus.res_id, 2);
    @(posedge clk);
    #1 bus.req = 4'b0001;
    @(posedge clk);
    #1 bus.req = '0;
    #2 rst = 1'b1;
    #1;
    check("arst_gnt", bus.gnt, 0);
    check("arst_done", bus.done, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_seg", bus.seg_out, 0);
    check("arst_y", bus.y_out, 0);
    base = ndone;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", ndone, base);
    drive(0, 2'b00, 4'h1);
    drive(1, 2'b01, 4'h6);
    drive(2, 2'b10, 4'hB);
    drive(3, 2'b11, 4'hE);
    push(0, 2'b00, 4'h1);
    push(1, 2'b01, 4'h6);
    push(2, 2'b10, 4'hB);
    push(3, 2'b11, 4'hE);
    push(0, 2'b00, 4'h1);
    done_t.delete();
    base = ndone;
    @(posedge clk);
    #1 bus.req = 4'b1111;
    for (int i = 0; i < 60 && ndone < base + 4; i++) @(negedge clk);
    for (int i = 0; i < 12 && bus.gnt != 4'b0001; i++) @(negedge clk);
    bus.req = '0;
    wait_done();
    if (done_t.size() == 5)
      for (int i = 1; i < 5; i++) check("rot_spacing", done_t[i] - done_t[i-1], 7);
    else check("rot_count", done_t.size(), 5);
    serve(1, 2'b01, 4'h3);
    drive(1, 2'b10, 4'hC);
    wait_done();
    for (int v = 0; v < 64; v++) begin
      logic [5:0] vv;
      vv = 6'(v);
      serve(0, vv[5:4], vv[3:0]);
      wait_done();
    end
    {last_y, last_seg} = princ(2'b11, 4'h5);
    serve(3, 2'b11, 4'h5);
    repeat (5) @(negedge clk);
    check("hold_busy", bus.busy, 1);
    check("hold_seg", bus.seg_out, last_seg);
    @(negedge clk);
    check("idle_busy_end", bus.busy, 0);
`ifdef AVAL_BLANK_EN
    last_seg = '0;
    last_y = '0;
`endif
    check("idle_seg_first", bus.seg_out, last_seg);
    check("idle_y_first", bus.y_out, last_y);
    check("idle_id_kept", bus.res_id, 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_seg", bus.seg_out, last_seg);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
